// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the three regfile write ports W0/W1/W2 among
// NUM_REQ writeback requesters using round-robin. After reset it zero-fills
// every entry before any requester is served. All write-port outputs are
// registered. req_ready is combinational.
// Optional feature: define REGFILE_WB_SKIP_INIT_EN to remove the zero-fill.
// With it defined, the block leaves reset directly into normal arbitration.
module regfile_wb_arbiter #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned ENTRIES = 80,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      W0_en,
    output logic [ADDR_W-1:0]         W0_addr,
    output logic [DATA_W-1:0]         W0_data,
    output logic                      W1_en,
    output logic [ADDR_W-1:0]         W1_addr,
    output logic [DATA_W-1:0]         W1_data,
    output logic                      W2_en,
    output logic [ADDR_W-1:0]         W2_addr,
    output logic [DATA_W-1:0]         W2_data,
    output logic                      init_done,
    output logic                      err_oob
);

    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned RR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned RR_XW     = RR_W + 1;
    localparam int unsigned ADDR_XW   = ADDR_W + 1;
    localparam logic [ADDR_XW-1:0] ENTRIES_X = ADDR_XW'(ENTRIES);
    localparam logic [RR_W-1:0]    LAST_REQ  = RR_W'(NUM_REQ - 1);

    // Split the packed request buses into per-requester views.
    logic [ADDR_W-1:0] addr_a [NUM_REQ];
    logic [DATA_W-1:0] data_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign data_a[g] = req_data[g*DATA_W +: DATA_W];
    end

`ifndef REGFILE_WB_SKIP_INIT_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] init_ptr_q;
    logic              init_last_c;
`endif

    logic [RR_W-1:0]      rr_q;
    logic [RR_W-1:0]      rr_d;
    logic                 run_c;
    logic [NUM_REQ-1:0]   grant_c;
    logic [NUM_PORTS-1:0] slot_vld_c;
    logic [ADDR_W-1:0]    slot_addr_c [NUM_PORTS];
    logic [DATA_W-1:0]    slot_data_c [NUM_PORTS];

    logic [NUM_PORTS-1:0] wen_d;
    logic [ADDR_W-1:0]    waddr_d [NUM_PORTS];
    logic [DATA_W-1:0]    wdata_d [NUM_PORTS];
    logic                 oob_d;

    logic [NUM_PORTS-1:0] wen_q;
    logic [ADDR_W-1:0]    waddr_q [NUM_PORTS];
    logic [DATA_W-1:0]    wdata_q [NUM_PORTS];
    logic                 init_done_q;
    logic                 err_oob_q;

    // Requesters are only served in RUN. Reset masks every grant in the same cycle.
`ifdef REGFILE_WB_SKIP_INIT_EN
    assign run_c = ~reset;
`else
    assign run_c = ~reset & (state_q == ST_RUN);
`endif

    // Round-robin scan from rr_q that grants up to three requests with distinct addresses.
    always_comb begin : arb
        logic [RR_XW-1:0] pos;
        logic [RR_W-1:0]  idx;
        logic [CNT_W-1:0] cnt;
        logic             hit;
        pos        = '0;
        idx        = '0;
        cnt        = '0;
        hit        = 1'b0;
        grant_c    = '0;
        slot_vld_c = '0;
        rr_d       = rr_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            slot_addr_c[p] = '0;
            slot_data_c[p] = '0;
        end
        if (run_c) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                pos = {1'b0, rr_q} + RR_XW'(k);
                if (pos >= RR_XW'(NUM_REQ)) begin
                    pos = pos - RR_XW'(NUM_REQ);
                end
                idx = pos[RR_W-1:0];
                hit = 1'b0;
                for (int p = 0; p < NUM_PORTS; p++) begin
                    if (slot_vld_c[p] && (slot_addr_c[p] == addr_a[idx])) begin
                        hit = 1'b1;
                    end
                end
                if (req_valid[idx] && (cnt < CNT_W'(NUM_PORTS)) && !hit) begin
                    grant_c[idx] = 1'b1;
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (CNT_W'(p) == cnt) begin
                            slot_vld_c[p]  = 1'b1;
                            slot_addr_c[p] = addr_a[idx];
                            slot_data_c[p] = data_a[idx];
                        end
                    end
                    cnt  = cnt + CNT_W'(1);
                    rr_d = (idx == LAST_REQ) ? '0 : idx + RR_W'(1);
                end
            end
        end
    end

    assign req_ready = grant_c;

`ifndef REGFILE_WB_SKIP_INIT_EN
    // Last zero-fill cycle: after this cycle, the next triple would start at or past the end.
    assign init_last_c = (({1'b0, init_ptr_q} + ADDR_XW'(NUM_PORTS)) >= ENTRIES_X);
`endif

    // Next write-port contents: the zero-fill triple in INIT, otherwise the granted slots.
    always_comb begin : wr_next
        logic [ADDR_XW-1:0] ia;
        ia    = '0;
        oob_d = 1'b0;
        wen_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            waddr_d[p] = slot_addr_c[p];
            wdata_d[p] = slot_data_c[p];
            wen_d[p]   = slot_vld_c[p] & ({1'b0, slot_addr_c[p]} < ENTRIES_X);
            oob_d      = oob_d | (slot_vld_c[p] & ~wen_d[p]);
        end
`ifndef REGFILE_WB_SKIP_INIT_EN
        if (state_q == ST_INIT) begin
            oob_d = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                ia         = {1'b0, init_ptr_q} + ADDR_XW'(p);
                waddr_d[p] = ia[ADDR_W-1:0];
                wdata_d[p] = '0;
                wen_d[p]   = (ia < ENTRIES_X);
            end
        end
`endif
    end

    // Control FSM and registered write-port outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            wen_q       <= '0;
            init_done_q <= 1'b0;
            err_oob_q   <= 1'b0;
            rr_q        <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                waddr_q[p] <= '0;
                wdata_q[p] <= '0;
            end
`ifndef REGFILE_WB_SKIP_INIT_EN
            state_q    <= ST_INIT;
            init_ptr_q <= '0;
`endif
        end else begin
            wen_q     <= wen_d;
            err_oob_q <= oob_d;
            rr_q      <= rr_d;
            for (int p = 0; p < NUM_PORTS; p++) begin
                waddr_q[p] <= waddr_d[p];
                wdata_q[p] <= wdata_d[p];
            end
`ifdef REGFILE_WB_SKIP_INIT_EN
            init_done_q <= 1'b1;
`else
            init_done_q <= (state_q == ST_RUN);
            if (state_q == ST_INIT) begin
                init_ptr_q <= init_ptr_q + ADDR_W'(NUM_PORTS);
                if (init_last_c) begin
                    state_q <= ST_RUN;
                end
            end
`endif
        end
    end

    assign W0_en     = wen_q[0];
    assign W0_addr   = waddr_q[0];
    assign W0_data   = wdata_q[0];
    assign W1_en     = wen_q[1];
    assign W1_addr   = waddr_q[1];
    assign W1_data   = wdata_q[1];
    assign W2_en     = wen_q[2];
    assign W2_addr   = waddr_q[2];
    assign W2_data   = wdata_q[2];
    assign init_done = init_done_q;
    assign err_oob   = err_oob_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for regfile_wb_arbiter.
// The driver steps a reference model for each cycle. The model queues the
// expected req_ready and the expected write-port outputs for the next cycle.
// A monitor compares these against the DUT on every falling edge.
module tb_regfile_wb_arbiter;

    localparam int NR = 5;
    localparam int NE = 80;
    localparam int AW = 7;
    localparam int DW = 64;

    logic              clock = 1'b1;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic              W0_en, W1_en, W2_en;
    logic [AW-1:0]     W0_addr, W1_addr, W2_addr;
    logic [DW-1:0]     W0_data, W1_data, W2_data;
    logic              init_done;
    logic              err_oob;

    regfile_wb_arbiter #(.NUM_REQ(NR), .ENTRIES(NE), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .W0_en     (W0_en),
        .W0_addr   (W0_addr),
        .W0_data   (W0_data),
        .W1_en     (W1_en),
        .W1_addr   (W1_addr),
        .W1_data   (W1_data),
        .W2_en     (W2_en),
        .W2_addr   (W2_addr),
        .W2_data   (W2_data),
        .init_done (init_done),
        .err_oob   (err_oob)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        int            due;
        logic [NR-1:0] rdy;
    } rdy_t;

    typedef struct packed {
        int                  due;
        logic                chk_all;
        logic [2:0]          en;
        logic [2:0][AW-1:0]  addr;
        logic [2:0][DW-1:0]  data;
        logic                done;
        logic                oob;
    } wb_t;

    rdy_t rdy_q[$];
    wb_t  wb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    // Requester side: pending requests, which are held until the model grants them.
    bit          pend   [NR];
    int          p_addr [NR];
    logic [63:0] p_data [NR];

    // Model state: zero-fill progress and round-robin start position.
    bit m_init;
    int m_base;
    int m_rr;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
        end
    endtask

    // Reference behaviour for one cycle, using the current pending requests as inputs.
    task automatic step(input bit rst, output logic [NR-1:0] g);
        wb_t  e;
        rdy_t r;
        int   taken[$];
        int   last;
        int   i;
        e     = '0;
        e.due = cyc + 1;
        g     = '0;
        last  = -1;
        if (rst) begin
            m_init    = 1;
            m_base    = 0;
            m_rr      = 0;
            e.chk_all = 1'b1;
        end else if (m_init) begin
            for (int p = 0; p < 3; p++) begin
                e.en[p]   = (m_base + p < NE);
                e.addr[p] = AW'(m_base + p);
            end
            if (m_base + 3 >= NE) m_init = 0;
            m_base += 3;
        end else begin
            e.done = 1'b1;
            for (int k = 0; k < NR; k++) begin
                bit clash;
                clash = 0;
                i = (m_rr + k) % NR;
                foreach (taken[t]) if (taken[t] == p_addr[i]) clash = 1;
                if (pend[i] && taken.size() < 3 && !clash) begin
                    int s;
                    s = taken.size();
                    g[i]      = 1'b1;
                    e.addr[s] = AW'(p_addr[i]);
                    e.data[s] = p_data[i];
                    if (p_addr[i] < NE) e.en[s] = 1'b1;
                    else                e.oob   = 1'b1;
                    taken.push_back(p_addr[i]);
                    last = i;
                end
            end
            if (last >= 0) m_rr = (last + 1) % NR;
        end
        r.due = cyc;
        r.rdy = g;
        rdy_q.push_back(r);
        wb_q.push_back(e);
    endtask

    task automatic raise(input int i, input int a);
        pend[i]   = 1;
        p_addr[i] = a;
        p_data[i] = {$urandom, $urandom};
    endtask

    function automatic int rand_addr();
        int s;
        s = int'($urandom_range(0, 7));
        if (s == 0)     return int'($urandom_range(NE, 127));
        else if (s < 4) return int'($urandom_range(0, 7));
        else            return int'($urandom_range(0, NE - 1));
    endfunction

    // Drive one cycle of inputs, step the model, retire grants and advance to just after the next edge.
    task automatic tick(input bit rst);
        logic [NR-1:0] g;
        reset = rst;
        for (int i = 0; i < NR; i++) begin
            req_valid[i]            = pend[i];
            req_addr[i*AW +: AW]    = AW'(p_addr[i]);
            req_data[i*DW +: DW]    = p_data[i];
        end
        step(rst, g);
        for (int i = 0; i < NR; i++) if (g[i]) pend[i] = 0;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic random_phase(input int n);
        repeat (n) begin
            for (int i = 0; i < NR; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1) raise(i, rand_addr());
            tick(0);
        end
    endtask

    // Monitor: compares the DUT against expectations that are due in the current cycle.
    initial begin : monitor
        rdy_t               r;
        wb_t                e;
        logic [2:0][AW-1:0] aa;
        logic [2:0][DW-1:0] ad;
        forever begin
            @(negedge clock);
            aa = {W2_addr, W1_addr, W0_addr};
            ad = {W2_data, W1_data, W0_data};
            while (rdy_q.size() > 0 && rdy_q[0].due <= cyc) begin
                r = rdy_q.pop_front();
                check("req_ready", 64'(req_ready), 64'(r.rdy));
            end
            while (wb_q.size() > 0 && wb_q[0].due <= cyc) begin
                e = wb_q.pop_front();
                check("wr_en", 64'({W2_en, W1_en, W0_en}), 64'(e.en));
                check("init_done", 64'(init_done), 64'(e.done));
                check("err_oob", 64'(err_oob), 64'(e.oob));
                for (int p = 0; p < 3; p++) begin
                    if (e.en[p] || e.chk_all) begin
                        check($sformatf("W%0d_addr", p), 64'(aa[p]), 64'(e.addr[p]));
                        check($sformatf("W%0d_data", p), ad[p], e.data[p]);
                    end
                end
            end
        end
    end

    initial begin : driver
        for (int i = 0; i < NR; i++) begin
            pend[i]   = 0;
            p_addr[i] = 0;
            p_data[i] = '0;
        end
        m_init = 1;
        m_base = 0;
        m_rr   = 0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        // Reset for two cycles, then the 27-cycle zero-fill runs with no requests pending.
        tick(1);
        tick(1);
        repeat (27) tick(0);

        // Full load from rr=0 with addresses 10..14.
        for (int i = 0; i < NR; i++) raise(i, 10 + i);
        tick(0);
        tick(0);
        tick(0);

        // Move rr to 3, then wrap around with valid=11011.
        raise(2, 20);
        tick(0);
        raise(3, 21); raise(4, 22); raise(0, 23); raise(1, 24);
        tick(0);
        tick(0);

        // Move rr back to 0, then test an address conflict: req0 and req1 both use 5, req2 uses 6.
        raise(4, 30);
        tick(0);
        raise(0, 5); raise(1, 5); raise(2, 6);
        tick(0);
        tick(0);

        // A single out-of-range request.
        raise(3, 90);
        tick(0);
        tick(0);
        tick(0);

        random_phase(300);

        // Reset during RUN with all requesters valid; the requests stay pending through INIT.
        for (int i = 0; i < NR; i++) if (!pend[i]) raise(i, rand_addr());
        tick(1);
        repeat (10) tick(0);
        // Reset again during INIT.
        tick(1);
        repeat (27) tick(0);

        random_phase(200);

        // Drain the pending requests.
        repeat (20) tick(0);

        @(negedge clock);
        #1;
        check("scoreboard_drained", 64'(rdy_q.size() + wb_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
